ddr3_frame_reader: RTL and testbench

- DDR3-side ping-pong frame fetcher. It sits directly downstream of the DDR3 CSR block and consumes its buffer-full flags and buffer offsets.
- On each frame start it selects a filled buffer and reads the whole frame from DDR3 over an Avalon-MM burst master. The words go into the pixel FIFO that feeds the VGA timing block.
- It releases a displayed buffer back to the CPU with a one-cycle clear pulse once a newer buffer has replaced it.

---
 rtl/ddr3_frame_reader_pkg.sv | 19 +
 rtl/ddr3_frame_reader_credit.sv | 21 ++
 rtl/ddr3_frame_reader.sv | 170 +++++++++++++++++
 tb/tb_ddr3_frame_reader.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_frame_reader_pkg.sv
// Shared types and widths for the DDR3 ping-pong frame reader.
package ddr3_frame_reader_pkg;

  localparam int ADDR_W       = 26;
  localparam int BURSTCOUNT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    REQ    = 2'd2,
    DATA   = 2'd3
  } state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ddr3_frame_reader_credit.sv
// Pixel FIFO free-space calculation and burst permit, purely combinational.
// A full burst is permitted only when the whole burst fits in the FIFO.
module frame_reader_credit #(
  parameter int FIFO_AW   = 9,
  parameter int BURST_LEN = 16
) (
  input  logic [FIFO_AW:0] fifo_used,
  output logic             burst_ok
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic [FIFO_AW+1:0] diff;
  logic [FIFO_AW:0]   free_space;

  // Extra bit catches a fill level reported above the depth.
  assign diff       = (FIFO_AW+2)'(DEPTH) - {1'b0, fifo_used};
  assign free_space = diff[FIFO_AW+1] ? '0 : diff[FIFO_AW:0];
  assign burst_ok   = ({1'b0, free_space} >= (FIFO_AW+2)'(BURST_LEN));

endmodule

// File: rtl/ddr3_frame_reader.sv
// Ping-pong frame fetcher: one Avalon burst outstanding, read data passed to the pixel FIFO with zero latency.
// Bursts are held back until the FIFO can take a full burst. FRAME_READER_STATS_EN adds frame/skip/overrun counters.
module ddr3_frame_reader
  import ddr3_frame_reader_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int BURST_LEN   = 16,
  parameter int FRAME_WORDS = 307200,
  parameter int FIFO_AW     = 9
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    frame_start,
  input  logic                    buffer0_empty,
  input  logic                    buffer1_empty,
  input  logic [ADDR_W-1:0]       buffer0_offset,
  input  logic [ADDR_W-1:0]       buffer1_offset,
  output logic                    clear_buffer0,
  output logic                    clear_buffer1,
  output logic [ADDR_W-1:0]       avm_address,
  output logic                    avm_read,
  output logic [BURSTCOUNT_W-1:0] avm_burstcount,
  input  logic                    avm_waitrequest,
  input  logic [DATA_W-1:0]       avm_readdata,
  input  logic                    avm_readdatavalid,
  output logic                    fifo_wr_en,
  output logic [DATA_W-1:0]       fifo_wr_data,
  input  logic [FIFO_AW:0]        fifo_used,
  output logic                    frame_active,
  output logic                    cur_sel
`ifdef FRAME_READER_STATS_EN
  ,
  output logic [15:0]             frame_count,
  output logic [15:0]             skip_count,
  output logic [15:0]             overrun_count
`endif
);

  localparam int WCNT_W = cnt_w(FRAME_WORDS + 1);
  localparam int BCNT_W = cnt_w(BURST_LEN);

  state_t              state_q, state_d;
  logic                cur_valid_q;
  logic [ADDR_W-1:0]   base_q;
  logic [WCNT_W-1:0]   wcnt_q;
  logic [BCNT_W-1:0]   bcnt_q;
  logic                pending_q;
  logic                req_hold_q;

  logic                burst_ok;
  logic                other_sel, other_full, cur_full;
  logic                sel_switch, sel_repeat;
  logic                beat, last_beat, frame_done, overrun;

  frame_reader_credit #(
    .FIFO_AW   (FIFO_AW),
    .BURST_LEN (BURST_LEN)
  ) u_credit (
    .fifo_used (fifo_used),
    .burst_ok  (burst_ok)
  );

  assign other_sel  = ~cur_sel;
  assign other_full = other_sel ? ~buffer1_empty : ~buffer0_empty;
  assign cur_full   = cur_sel   ? ~buffer1_empty : ~buffer0_empty;
  assign sel_switch = other_full;
  assign sel_repeat = ~other_full & cur_full & cur_valid_q;

  assign beat       = (state_q == DATA) & avm_readdatavalid;
  assign last_beat  = beat & (bcnt_q == BCNT_W'(BURST_LEN - 1));
  assign frame_done = (wcnt_q == WCNT_W'(FRAME_WORDS - 1));
  assign overrun    = frame_start & ((state_q == REQ) | (state_q == DATA));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    avm_read      = 1'b0;
    clear_buffer0 = 1'b0;
    clear_buffer1 = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_start) state_d = SELECT;
      end
      SELECT: begin
        if (sel_switch) begin
          state_d = REQ;
          if (cur_valid_q) begin
            clear_buffer0 = ~cur_sel;
            clear_buffer1 = cur_sel;
          end
        end else if (sel_repeat) begin
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        // A request already stalled must complete; an unissued one is dropped on overrun.
        avm_read = req_hold_q | (burst_ok & ~pending_q);
        if (avm_read & ~avm_waitrequest)  state_d = DATA;
        else if (pending_q & ~req_hold_q) state_d = SELECT;
      end
      DATA: begin
        if (last_beat) begin
          if (pending_q | frame_start) state_d = SELECT;
          else if (frame_done)         state_d = IDLE;
          else                         state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_sel     <= 1'b0;
      cur_valid_q <= 1'b0;
      base_q      <= '0;
      wcnt_q      <= '0;
      bcnt_q      <= '0;
      pending_q   <= 1'b0;
      req_hold_q  <= 1'b0;
    end else begin
      pending_q  <= (state_d == SELECT) ? 1'b0 : (pending_q | overrun);
      req_hold_q <= avm_read & avm_waitrequest;
      if (state_q == SELECT) begin
        wcnt_q <= '0;
        bcnt_q <= '0;
        if (sel_switch) begin
          cur_sel     <= other_sel;
          cur_valid_q <= 1'b1;
          base_q      <= other_sel ? buffer1_offset : buffer0_offset;
        end else if (sel_repeat) begin
          base_q      <= cur_sel ? buffer1_offset : buffer0_offset;
        end
      end else if (beat) begin
        wcnt_q <= wcnt_q + 1'b1;
        bcnt_q <= last_beat ? '0 : bcnt_q + 1'b1;
      end
    end
  end

  assign frame_active   = (state_q == REQ) | (state_q == DATA);
  assign avm_address    = (state_q == REQ) ? base_q + ADDR_W'(wcnt_q) : '0;
  assign avm_burstcount = frame_active ? BURSTCOUNT_W'(BURST_LEN) : '0;
  assign fifo_wr_en     = beat;
  assign fifo_wr_data   = beat ? avm_readdata : '0;

`ifdef FRAME_READER_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count   <= '0;
      skip_count    <= '0;
      overrun_count <= '0;
    end else begin
      if (last_beat && frame_done && frame_count != 16'hFFFF)
        frame_count <= frame_count + 1'b1;
      if (state_q == SELECT && state_d == IDLE && skip_count != 16'hFFFF)
        skip_count <= skip_count + 1'b1;
      if (overrun && overrun_count != 16'hFFFF)
        overrun_count <= overrun_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ddr3_frame_reader.sv
// Randomised bench for ddr3_frame_reader against a frame-level reference model and an Avalon memory slave.
module tb_ddr3_frame_reader;

  localparam int FW = 64;
  localparam int BL = 16;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, frame_start, buffer0_empty, buffer1_empty;
  logic [25:0] buffer0_offset, buffer1_offset;
  logic        clear_buffer0, clear_buffer1;
  logic [25:0] avm_address;
  logic        avm_read;
  logic [7:0]  avm_burstcount;
  logic        avm_waitrequest, avm_readdatavalid;
  logic [31:0] avm_readdata;
  logic        fifo_wr_en;
  logic [31:0] fifo_wr_data;
  logic [9:0]  fifo_used;
  logic        frame_active, cur_sel;
`ifdef FRAME_READER_STATS_EN
  logic [15:0] frame_count, skip_count, overrun_count;
`endif

  ddr3_frame_reader #(
    .DATA_W(32), .BURST_LEN(BL), .FRAME_WORDS(FW), .FIFO_AW(9)
  ) dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start),
    .buffer0_empty(buffer0_empty), .buffer1_empty(buffer1_empty),
    .buffer0_offset(buffer0_offset), .buffer1_offset(buffer1_offset),
    .clear_buffer0(clear_buffer0), .clear_buffer1(clear_buffer1),
    .avm_address(avm_address), .avm_read(avm_read), .avm_burstcount(avm_burstcount),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_used(fifo_used),
    .frame_active(frame_active), .cur_sel(cur_sel)
`ifdef FRAME_READER_STATS_EN
    , .frame_count(frame_count), .skip_count(skip_count), .overrun_count(overrun_count)
`endif
  );

  int          n_cmp = 0, n_err = 0;
  logic [31:0] seed;
  logic [31:0] wr_q[$], exp_wr[$];
  logic [25:0] addr_q[$], exp_addr[$], beat_q[$];
  int          c0 = 0, c1 = 0, exp_c0 = 0, exp_c1 = 0, wr_rst = 0;
  bit          m_cur, m_valid;
  int          exp_frames = 0, exp_skip = 0, exp_ovr = 0;
  bit          stall_en = 0, wr_force = 0, fu_manual = 0, force_rv = 0, flush = 0;
  int          fu_val = 0;
  bit          prev_stall = 0;
  logic [25:0] prev_addr = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memfn(input logic [25:0] a);
    return {a, a[25:20]} ^ seed;
  endfunction

  // Frame-level reference: which buffer is shown, what gets released, which words arrive.
  function automatic void model_frame(input bit e0, input bit e1,
                                      input logic [25:0] o0, input logic [25:0] o1,
                                      input int nwords);
    bit other, of, cf, go;
    logic [25:0] base;
    other = ~m_cur;
    of = other ? !e1 : !e0;
    cf = m_cur ? !e1 : !e0;
    go = 0;
    if (of) begin
      if (m_valid) begin
        if (m_cur) exp_c1++; else exp_c0++;
      end
      m_cur = other; m_valid = 1; go = 1;
    end else if (cf && m_valid) begin
      go = 1;
    end
    if (go) begin
      base = m_cur ? o1 : o0;
      for (int k = 0; k < nwords / BL; k++) exp_addr.push_back(base + 26'(k * BL));
      for (int i = 0; i < nwords; i++) exp_wr.push_back(memfn(base + 26'(i)));
      if (nwords == FW) exp_frames++;
    end else begin
      exp_skip++;
    end
  endfunction

  // Monitor plus Avalon memory slave, one process so all slave inputs have a single driver.
  initial begin
    avm_waitrequest = 0; avm_readdatavalid = 0; avm_readdata = '0; fifo_used = '0;
    forever begin
      @(negedge clk);
      if (fifo_wr_en) begin
        if (reset_n) wr_q.push_back(fifo_wr_data);
        else         wr_rst++;
      end
      if (clear_buffer0) c0++;
      if (clear_buffer1) c1++;
      if (clear_buffer0 || clear_buffer1)
        chk("clear_exclusive", {63'b0, clear_buffer0 & clear_buffer1}, 64'd0);
      if (reset_n && avm_read) begin
        chk("burstcount", avm_burstcount, 64'd16);
        if (!prev_stall) chk("credit_ok", {63'b0, fifo_used <= 10'd496}, 64'd1);
      end
      if (reset_n && prev_stall) begin
        chk("hold_read", avm_read, 64'd1);
        chk("hold_addr", avm_address, prev_addr);
      end
      if (reset_n && avm_read && !avm_waitrequest) begin
        addr_q.push_back(avm_address);
        for (int i = 0; i < BL; i++) beat_q.push_back(avm_address + 26'(i));
      end
      prev_stall = reset_n && avm_read && avm_waitrequest;
      prev_addr  = avm_address;

      @(posedge clk); #1;
      if (flush) beat_q.delete();
      avm_waitrequest = wr_force || (stall_en && ($urandom_range(0, 2) == 0));
      if (beat_q.size() > 0 && (force_rv || $urandom_range(0, 3) != 0)) begin
        avm_readdatavalid = 1;
        avm_readdata      = memfn(beat_q.pop_front());
      end else begin
        avm_readdatavalid = 0;
        avm_readdata      = $urandom;
      end
      if (fu_manual) fifo_used = 10'(fu_val);
      else if ($urandom_range(0, 7) == 0) fifo_used = 10'($urandom_range(497, 512));
      else fifo_used = 10'($urandom_range(0, 496));
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_read"},    avm_read, 64'd0);
    chk({tag, "_addr"},    avm_address, 64'd0);
    chk({tag, "_bcount"},  avm_burstcount, 64'd0);
    chk({tag, "_wr_en"},   fifo_wr_en, 64'd0);
    chk({tag, "_wr_data"}, fifo_wr_data, 64'd0);
    chk({tag, "_clr0"},    clear_buffer0, 64'd0);
    chk({tag, "_clr1"},    clear_buffer1, 64'd0);
    chk({tag, "_active"},  frame_active, 64'd0);
    chk({tag, "_cur_sel"}, cur_sel, 64'd0);
  endtask

  task automatic clear_capture();
    wr_q.delete(); addr_q.delete(); exp_wr.delete(); exp_addr.delete();
    c0 = 0; c1 = 0; exp_c0 = 0; exp_c1 = 0;
  endtask

  task automatic set_bufs(input bit e0, input bit e1, input logic [25:0] o0, input logic [25:0] o1);
    buffer0_empty = e0; buffer1_empty = e1; buffer0_offset = o0; buffer1_offset = o1;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1; frame_start = 1;
    @(posedge clk); #1; frame_start = 0;
  endtask

  task automatic wait_idle();
    int quiet = 0;
    int n = 0;
    repeat (3) @(negedge clk);
    while (quiet < 2 && n < 3000) begin
      @(negedge clk);
      n++;
      quiet = frame_active ? 0 : quiet + 1;
    end
    if (quiet < 2) chk("idle_reached", quiet, 64'd2);
  endtask

  task automatic compare_frame(input string tag);
    int bad = 0;
    chk({tag, "_nwords"}, wr_q.size(), exp_wr.size());
    for (int i = 0; i < wr_q.size() && i < exp_wr.size(); i++)
      if (wr_q[i] !== exp_wr[i]) bad++;
    chk({tag, "_data_bad"}, bad, 64'd0);
    chk({tag, "_nbursts"}, addr_q.size(), exp_addr.size());
    bad = 0;
    for (int i = 0; i < addr_q.size() && i < exp_addr.size(); i++)
      if (addr_q[i] !== exp_addr[i]) bad++;
    chk({tag, "_addr_bad"}, bad, 64'd0);
    chk({tag, "_clr0"}, c0, exp_c0);
    chk({tag, "_clr1"}, c1, exp_c1);
    chk({tag, "_cur_sel"}, cur_sel, m_cur);
  endtask

  task automatic run_frame(input string tag, input bit e0, input bit e1,
                           input logic [25:0] o0, input logic [25:0] o1);
    clear_capture();
    set_bufs(e0, e1, o0, o1);
    model_frame(e0, e1, o0, o1, FW);
    pulse_start();
    wait_idle();
    compare_frame(tag);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    logic [25:0] o0, o1;
    reset_n = 0; frame_start = 0;
    set_bufs(1, 1, '0, '0);
    seed = $urandom;
    m_cur = 0; m_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    reset_n = 1;

    run_frame("buf0", 0, 1, 26'h100, 26'h0);
    run_frame("wrap", 0, 0, 26'h100, 26'h3FFFFF8);
    run_frame("skip", 1, 1, 26'h100, 26'h3FFFFF8);
`ifdef FRAME_READER_STATS_EN
    chk("skip_count", skip_count, exp_skip);
`endif

    // FIFO nearly full blocks the request; a stalled request must hold still.
    clear_capture();
    fu_manual = 1; fu_val = 500;
    o0 = 26'($urandom);
    set_bufs(0, 1, o0, 26'h0);
    model_frame(0, 1, o0, 26'h0, FW);
    pulse_start();
    repeat (2) @(negedge clk);
    repeat (4) begin
      @(negedge clk);
      chk("credit_block_read", avm_read, 64'd0);
      chk("credit_block_active", frame_active, 64'd1);
    end
    fu_val = 496; wr_force = 1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_read", avm_read, 64'd1);
      chk("stall_addr", avm_address, exp_addr[0]);
    end
    wr_force = 0; fu_manual = 0;
    wait_idle();
    compare_frame("credit");

    for (int f = 0; f < 10; f++) begin
      stall_en = ($urandom_range(0, 1) == 1);
      run_frame($sformatf("rand%0d", f), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                26'($urandom), 26'($urandom));
    end

    // Overrun partway through the second burst.
    clear_capture();
    stall_en = 1;
    o0 = 26'($urandom); o1 = 26'($urandom);
    set_bufs(0, 0, o0, o1);
    model_frame(0, 0, o0, o1, 2 * BL);
    pulse_start();
    n = 0;
    while (wr_q.size() < BL + 5 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (wr_q.size() < BL + 5) chk("overrun_reach", wr_q.size(), BL + 5);
    pulse_start();
    exp_ovr++;
    model_frame(0, 0, o0, o1, FW);
    wait_idle();
    compare_frame("overrun");
`ifdef FRAME_READER_STATS_EN
    chk("frame_count", frame_count, exp_frames);
    chk("overrun_count", overrun_count, exp_ovr);
`endif

    // Reset in the middle of a burst; late beats must not reach the FIFO.
    clear_capture();
    stall_en = 0;
    set_bufs(0, 1, 26'h2000, 26'h0);
    pulse_start();
    n = 0;
    while (wr_q.size() < 3 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    reset_n = 0; force_rv = 1;
    #1;
    chk_zero("midreset");
    repeat (4) @(negedge clk);
    chk("wr_during_reset", wr_rst, 64'd0);
    force_rv = 0; flush = 1;
    m_cur = 0; m_valid = 0; exp_frames = 0; exp_skip = 0; exp_ovr = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1; flush = 0;

    run_frame("post_reset_a", 1, 0, 26'h0, 26'h1234);
    stall_en = 1;
    run_frame("post_reset_b", 0, 0, 26'($urandom), 26'($urandom));
`ifdef FRAME_READER_STATS_EN
    chk("frame_count_final", frame_count, exp_frames);
    chk("skip_count_final", skip_count, exp_skip);
    chk("overrun_count_final", overrun_count, exp_ovr);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
